// File: rtl/switch_event_servicer_if.sv
// switch_event_servicer_if: Avalon-MM link to the 8-bit switch PIO plus its irq line
interface switch_event_servicer_if;
    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        irq;
    modport master (
        output avm_address, avm_chipselect, avm_write_n, avm_writedata,
        input  avm_readdata, irq
    );
    modport slave (
        input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
        output avm_readdata, irq
    );
endinterface

// File: rtl/switch_event_servicer.sv
// switch_event_servicer: services switch PIO irqs and queues timestamped events in a FWFT FIFO
module switch_event_servicer #(
    parameter int         DEPTH     = 8,
    parameter int         TS_W      = 16,
    parameter logic [7:0] MASK_INIT = 8'hFF
) (
    input  logic                   clk,
    input  logic                   reset,
    switch_event_servicer_if.master bus,
    input  logic                   cfg_mask_valid,
    input  logic [7:0]             cfg_mask,
    output logic                   ev_valid,
    input  logic                   ev_ready,
    output logic [TS_W+15:0]       ev_data,
    output logic [15:0]            drop_count,
    output logic                   busy
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [2:0] {INIT, IDLE, RD_CAP, CAP_WAIT, CLR, RD_DAT, DAT_WAIT, PUSH} state_t;
    state_t          r_state, w_next;
    logic [TS_W-1:0] r_ts, r_ts_irq;
    logic [7:0]      r_cap, r_sw, r_mask;
    logic            r_pend;
    logic [AW:0]     r_wr, r_rd;
    logic [TS_W+15:0] r_mem [DEPTH];
    logic [15:0]     r_drop;
    logic [1:0]      r_addr;
    logic            r_cs, r_wn, r_busy;
    logic [31:0]     r_wd;
    logic            w_full, w_pop, w_push, w_drop, w_take;
    logic [23:0]     w_unused_rd;
    always_comb begin
        w_next = r_state;
        case (r_state)
            INIT:     w_next = r_wn ? INIT : IDLE;
            IDLE:     w_next = r_pend ? INIT : bus.irq ? RD_CAP : IDLE;
            RD_CAP:   w_next = CAP_WAIT;
            CAP_WAIT: w_next = (bus.avm_readdata[7:0] == 8'd0) ? IDLE : CLR;
            CLR:      w_next = RD_DAT;
            RD_DAT:   w_next = DAT_WAIT;
            DAT_WAIT: w_next = PUSH;
            default:  w_next = IDLE;
        endcase
    end
    assign ev_valid = r_wr != r_rd;
    assign w_full   = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_pop    = ev_valid && ev_ready;
    assign w_push   = r_state == PUSH;
    assign w_drop   = w_push && w_full && !w_pop;
    assign w_take   = (r_state == IDLE) && r_pend;
    // Bus outputs are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= INIT;
            r_ts    <= '0;
            r_pend  <= 1'b0;
            r_mask  <= MASK_INIT;
            r_wr    <= '0;
            r_rd    <= '0;
            r_drop  <= '0;
            r_addr  <= 2'd0;
            r_cs    <= 1'b0;
            r_wn    <= 1'b1;
            r_wd    <= '0;
            r_busy  <= 1'b1;
        end else begin
            r_state <= w_next;
            r_ts    <= r_ts + TS_W'(1);
            r_pend  <= cfg_mask_valid || (r_pend && !w_take);
            if (cfg_mask_valid) r_mask <= cfg_mask;
            if (r_state == IDLE) r_ts_irq <= r_ts;
            if (r_state == CAP_WAIT) r_cap <= bus.avm_readdata[7:0];
            if (r_state == DAT_WAIT) r_sw <= bus.avm_readdata[7:0];
            if (w_push && !w_drop) r_wr <= r_wr + (AW+1)'(1);
            if (w_pop) r_rd <= r_rd + (AW+1)'(1);
            if (w_drop && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
            r_cs   <= w_next != IDLE;
            r_busy <= w_next != IDLE;
            r_wn   <= !(w_next == INIT || w_next == CLR);
            r_addr <= (w_next == INIT) ? 2'd2 : (w_next == RD_CAP || w_next == CAP_WAIT || w_next == CLR) ? 2'd3 : 2'd0;
            r_wd   <= (w_next == INIT) ? {24'd0, r_mask} : 32'd0;
        end
    end
    always_ff @(posedge clk) begin
        if (!reset && w_push && !w_drop) r_mem[r_wr[AW-1:0]] <= {r_ts_irq, r_cap, r_sw};
    end
    assign ev_data            = r_mem[r_rd[AW-1:0]];
    assign drop_count         = r_drop;
    assign busy               = r_busy;
    assign bus.avm_address    = r_addr;
    assign bus.avm_chipselect = r_cs;
    assign bus.avm_write_n    = r_wn;
    assign bus.avm_writedata  = r_wd;
    assign w_unused_rd        = bus.avm_readdata[31:8];
endmodule

// File: tb/tb_switch_event_servicer.sv
// tb_switch_event_servicer: PIO environment, queue-based reference model and directed + random stimulus
module tb_switch_event_servicer;
    localparam int DEPTH = 8;
    localparam int K_IDLE = 0, K_HOLD = 1, K_INIT = 2, K_RD = 3, K_CAPW = 4, K_CLR = 5, K_DATW = 6, K_PUSH = 7;
    typedef struct {int kind; logic cs; logic wn; logic [1:0] addr; logic [7:0] wd;} op_t;

    logic clk = 1'b0, reset = 1'b1;
    always #5 clk = ~clk;
    switch_event_servicer_if bus ();
    logic        cfg_mask_valid = 1'b0;
    logic [7:0]  cfg_mask = 8'h00;
    logic        ev_valid, ev_ready = 1'b0, busy;
    logic [31:0] ev_data;
    logic [15:0] drop_count;
    logic [7:0]  sw = 8'h00;
    int          n_chk = 0, n_pass = 0, cyc_n = 0;

    switch_event_servicer dut (
        .clk(clk), .reset(reset), .bus(bus),
        .cfg_mask_valid(cfg_mask_valid), .cfg_mask(cfg_mask),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data),
        .drop_count(drop_count), .busy(busy)
    );

    function automatic logic [7:0] pio_rd(logic [1:0] a, logic [7:0] d, logic [7:0] ec, logic [7:0] m);
        return (a == 2'd0) ? d : (a == 2'd2) ? m : (a == 2'd3) ? ec : 8'h00;
    endfunction

    function automatic op_t mk(int k, logic cs, logic wn, logic [1:0] a, logic [7:0] wd);
        op_t o;
        o.kind = k; o.cs = cs; o.wn = wn; o.addr = a; o.wd = wd;
        return o;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc_n);
    endtask

    // switch PIO environment: any-edge capture, write to reg 3 clears all bits and wins over new edges
    logic [7:0] e_prev = 8'h00, e_ec = 8'h00, e_mask = 8'h00;
    initial bus.avm_readdata = 32'd0;
    assign bus.irq = |(e_ec & e_mask);
    always @(posedge clk) begin
        bus.avm_readdata <= {24'd0, pio_rd(bus.avm_address, sw, e_ec, e_mask)};
        e_prev <= sw;
        e_ec   <= (bus.avm_chipselect && !bus.avm_write_n && bus.avm_address == 2'd3) ? 8'h00 : (e_ec | (sw ^ e_prev));
        if (bus.avm_chipselect && !bus.avm_write_n && bus.avm_address == 2'd2) e_mask <= bus.avm_writedata[7:0];
        cyc_n  <= reset ? 0 : cyc_n + 1;
    end

    // reference: a plan of expected bus cycles, a private PIO copy and an event queue
    op_t         plan[$];
    logic [31:0] evq[$];
    logic [7:0]  m_prev = 8'h00, m_ec = 8'h00, m_mask = 8'h00, m_rd = 8'h00, m_cfg = 8'hFF, m_cap = 8'h00, m_sw = 8'h00;
    logic [15:0] m_ts = 16'd0, m_ts_irq = 16'd0, m_drop = 16'd0;
    logic        m_pend = 1'b0, m_on = 1'b0;
    always @(posedge clk) begin
        op_t        cur;
        logic       irq_m, pop;
        logic [7:0] rd_now;
        int         pre;
        cur    = (plan.size() != 0) ? plan[0] : mk(K_IDLE, 1'b0, 1'b1, 2'd0, 8'h00);
        rd_now = m_rd;
        m_rd   = pio_rd(cur.addr, sw, m_ec, m_mask);
        irq_m  = |(m_ec & m_mask);
        m_ec   = (cur.cs && !cur.wn && cur.addr == 2'd3) ? 8'h00 : (m_ec | (sw ^ m_prev));
        if (cur.cs && !cur.wn && cur.addr == 2'd2) m_mask = cur.wd;
        m_prev = sw;
        if (reset) begin
            plan.delete();
            plan.push_back(mk(K_HOLD, 1'b0, 1'b1, 2'd0, 8'h00));
            plan.push_back(mk(K_INIT, 1'b1, 1'b0, 2'd2, 8'hFF));
            evq.delete();
            m_drop = 16'd0; m_ts = 16'd0; m_pend = 1'b0; m_cfg = 8'hFF; m_on = 1'b1;
        end else begin
            pre = evq.size();
            pop = (pre != 0) && ev_ready;
            if (pop) void'(evq.pop_front());
            if (cur.kind == K_PUSH) begin
                if (pre == DEPTH && !pop) m_drop = (m_drop == 16'hFFFF) ? m_drop : m_drop + 16'd1;
                else evq.push_back({m_ts_irq, m_cap, m_sw});
            end
            if (plan.size() != 0) begin
                void'(plan.pop_front());
                if (cur.kind == K_CAPW) begin
                    m_cap = rd_now;
                    if (rd_now == 8'h00) plan.delete();
                end
                if (cur.kind == K_DATW) m_sw = rd_now;
            end else if (m_pend) begin
                plan.push_back(mk(K_INIT, 1'b1, 1'b0, 2'd2, m_cfg));
                m_pend = 1'b0;
            end else if (irq_m) begin
                m_ts_irq = m_ts;
                plan.push_back(mk(K_RD,   1'b1, 1'b1, 2'd3, 8'h00));
                plan.push_back(mk(K_CAPW, 1'b1, 1'b1, 2'd3, 8'h00));
                plan.push_back(mk(K_CLR,  1'b1, 1'b0, 2'd3, 8'h00));
                plan.push_back(mk(K_RD,   1'b1, 1'b1, 2'd0, 8'h00));
                plan.push_back(mk(K_DATW, 1'b1, 1'b1, 2'd0, 8'h00));
                plan.push_back(mk(K_PUSH, 1'b1, 1'b1, 2'd0, 8'h00));
            end
            if (cfg_mask_valid) begin
                m_cfg  = cfg_mask;
                m_pend = 1'b1;
            end
            m_ts = m_ts + 16'd1;
        end
    end

    always @(negedge clk) begin
        op_t c;
        if (m_on) begin
            c = (plan.size() != 0) ? plan[0] : mk(K_IDLE, 1'b0, 1'b1, 2'd0, 8'h00);
            chk("busy", busy, plan.size() != 0);
            chk("chipselect", bus.avm_chipselect, c.cs);
            chk("write_n", bus.avm_write_n, c.wn);
            if (c.kind != K_PUSH) chk("address", bus.avm_address, c.addr);
            chk("writedata", bus.avm_writedata, {24'd0, c.wd});
            chk("ev_valid", ev_valid, evq.size() != 0);
            if (evq.size() != 0) chk("ev_data", ev_data, evq[0]);
            chk("drop_count", drop_count, m_drop);
        end
    end

    task automatic drive();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_irq(output int t);
        t = -1;
        for (int i = 0; i < 30 && t < 0; i++) begin
            @(negedge clk);
            if (bus.irq && !busy) t = cyc_n;
        end
        if (t < 0) chk("irq_timeout", 32'd0, 32'd1);
    endtask

    task automatic burst(input logic [7:0] v);
        drive();
        sw = v;
        repeat (12) drive();
    endtask

    initial begin
        int t, mw;
        logic [7:0] exp6 [8];
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("init_bus", {bus.avm_chipselect, bus.avm_write_n, bus.avm_address}, 4'b1010);
        chk("init_wdata", bus.avm_writedata, 32'h0000_00FF);
        @(negedge clk);
        chk("init_busy", busy, 1'b0);

        drive();
        sw = 8'h05;
        wait_irq(t);
        repeat (3) @(negedge clk);
        chk("clr_write", {bus.avm_chipselect, bus.avm_write_n, bus.avm_address}, 4'b1011);
        repeat (4) @(negedge clk);
        chk("first_valid", ev_valid, 1'b1);
        chk("first_data", ev_data, {t[15:0], 16'h0505});
        drive(); ev_ready = 1'b1;
        drive(); ev_ready = 1'b0;

        for (int k = 0; k < 9; k++) burst(8'h10 + 8'(k));
        chk("fill_drop", drop_count, 16'd1);
        ev_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("drain_sw", {ev_valid, ev_data[7:0]}, {1'b1, 8'h10 + 8'(k)});
        end
        drive(); ev_ready = 1'b0;
        @(negedge clk);
        chk("drain_empty", ev_valid, 1'b0);

        drive();
        sw = 8'h33;
        wait_irq(t);
        drive(); cfg_mask_valid = 1'b1; cfg_mask = 8'h0F;
        drive(); cfg_mask_valid = 1'b0;
        mw = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (mw < 0 && bus.avm_chipselect && !bus.avm_write_n && bus.avm_address == 2'd2) begin
                mw = cyc_n;
                chk("mask_wdata", bus.avm_writedata, 32'h0000_000F);
            end
        end
        chk("mask_after_push", mw - t, 32'd8);
        drive(); ev_ready = 1'b1;
        drive(); ev_ready = 1'b0;
        drive(); sw = sw ^ 8'h80;
        repeat (15) @(negedge clk);
        chk("masked_irq", bus.irq, 1'b0);
        chk("masked_no_event", ev_valid, 1'b0);
        burst(sw ^ 8'h01);
        chk("stale_cap", {ev_valid, ev_data[15:8]}, {1'b1, 8'h81});

        drive();
        sw = sw ^ 8'h02;
        wait_irq(t);
        repeat (3) drive();
        reset = 1'b1;
        @(negedge clk);
        chk("clr_before_reset", {bus.avm_chipselect, bus.avm_write_n, bus.avm_address}, 4'b1011);
        drive(); reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 1'b1);
        chk("rst_ev_valid", ev_valid, 1'b0);
        chk("rst_drop", drop_count, 16'd0);
        @(negedge clk);
        chk("rst_mask_bus", {bus.avm_chipselect, bus.avm_write_n, bus.avm_address}, 4'b1010);
        chk("rst_mask_wdata", bus.avm_writedata, 32'h0000_00FF);

        for (int k = 0; k < 8; k++) burst(8'h40 + 8'(k));
        drive();
        sw = 8'h55;
        wait_irq(t);
        repeat (6) drive();
        ev_ready = 1'b1;
        drive(); ev_ready = 1'b0;
        @(negedge clk);
        chk("full_push_drop", drop_count, 16'd0);
        chk("full_push_head", ev_data[7:0], 8'h41);
        for (int k = 0; k < 7; k++) exp6[k] = 8'h41 + 8'(k);
        exp6[7] = 8'h55;
        drive(); ev_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("full_drain", {ev_valid, ev_data[7:0]}, {1'b1, exp6[k]});
        end
        drive(); ev_ready = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            drive();
            if ($urandom_range(7) == 0) sw = 8'($urandom);
            ev_ready       = $urandom_range(9) < 3;
            cfg_mask_valid = $urandom_range(63) == 0;
            cfg_mask       = 8'($urandom) | 8'h11;
            reset          = $urandom_range(499) == 0;
        end
        drive();
        reset = 1'b0; cfg_mask_valid = 1'b0; ev_ready = 1'b1;
        repeat (30) drive();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
